// File: rtl/memory_write_control_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_write_control_if
// Description : Frame-memory write bus (strobe, address, packed word, done).
// Revision    : 1.0  initial release
// ============================================================================
interface memory_write_control_if #(
  parameter int MEM_WIDTH  = 96,
  parameter int ADDR_WIDTH = 16
);
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [MEM_WIDTH-1:0]  wdata;
  logic                  frame_done;

  modport master (output wen, waddr, wdata, frame_done);
  modport slave  (input  wen, waddr, wdata, frame_done);
endinterface
`default_nettype wire

// File: rtl/memory_write_control.sv
`default_nettype none
// ============================================================================
// Module      : memory_write_control
// Description : Packs 2x2 pixel blocks of the video stream into memory words.
//               Optional partial-window write enabled by macro WMEM_WIN_EN.
// Revision    : 1.0  initial release
// ============================================================================
module memory_write_control #(
  parameter int DATA_WIDTH = 24,
  parameter int MEM_WIDTH  = DATA_WIDTH*4,
  parameter int ADDR_DEPTH = 512*512/4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int MAX_HRES   = 512
) (
  input  wire logic                  i_clk,
  input  wire logic                  rst,
  input  wire logic                  i_vsync,
  input  wire logic                  i_hsync,
  input  wire logic                  i_de,
  input  wire logic [DATA_WIDTH-1:0] i_data,
  input  wire logic [10:0]           i_hres,
  input  wire logic [10:0]           i_vres,
  input  wire logic [10:0]           i_PSC,
  input  wire logic [10:0]           i_PEC,
  input  wire logic [10:0]           i_SR,
  input  wire logic [10:0]           i_ER,
  memory_write_control_if.master     wr
);

  localparam int C_LB_DEPTH = MAX_HRES/2;
  localparam int C_LB_AW    = $clog2(C_LB_DEPTH);

  localparam logic [1:0] S_WIDLE = 2'd0;
  localparam logic [1:0] S_WARM  = 2'd1;
  localparam logic [1:0] S_WEVEN = 2'd2;
  localparam logic [1:0] S_WODD  = 2'd3;

  logic [1:0]            r_state, w_state_nxt;
  logic                  r_vsync_d, r_de_d;
  logic [10:0]           r_col_cnt, r_row_cnt;
  logic [DATA_WIDTH-1:0] r_hold_px;
  logic [2*DATA_WIDTH-1:0] r_lb_rd;
  logic [2*DATA_WIDTH-1:0] r_linebuf [C_LB_DEPTH];

  logic w_vs_rise, w_de_fall, w_line_act, w_pix, w_in_win, w_last, w_unused_win;
  logic [10:0] w_hres_m1, w_vres_m1, w_col_lim, w_row_lim, w_col_last, w_row_last;
  logic [21:0] w_addr_full;
  logic [C_LB_AW-1:0] w_lb_idx;
  logic [MEM_WIDTH-1:0] w_wdata;

  assign w_vs_rise = i_vsync & ~r_vsync_d;
  assign w_de_fall = ~i_de & r_de_d;
  assign w_hres_m1 = i_hres - 11'd1;
  assign w_vres_m1 = i_vres - 11'd1;

`ifdef WMEM_WIN_EN
  logic [10:0] w_psc, w_pec, w_sr, w_er;
  // Window edges snap outward/inward to whole 2x2 blocks.
  assign w_psc = {i_PSC[10:1], 1'b0};
  assign w_pec = {i_PEC[10:1], 1'b1};
  assign w_sr  = {i_SR[10:1], 1'b0};
  assign w_er  = {i_ER[10:1], 1'b1};
  assign w_in_win = (r_col_cnt >= w_psc) && (r_col_cnt <= w_pec) &&
                    (r_row_cnt >= w_sr)  && (r_row_cnt <= w_er)  &&
                    (r_col_cnt < i_hres) && (r_row_cnt < i_vres);
  assign w_col_lim = (w_pec < w_hres_m1) ? w_pec : w_hres_m1;
  assign w_row_lim = (w_er  < w_vres_m1) ? w_er  : w_vres_m1;
  assign w_unused_win = ^{i_hsync, i_PSC[0], i_PEC[0], i_SR[0], i_ER[0]};
`else
  assign w_in_win  = (r_col_cnt < i_hres) && (r_row_cnt < i_vres);
  assign w_col_lim = w_hres_m1;
  assign w_row_lim = w_vres_m1;
  assign w_unused_win = ^{i_hsync, i_PSC, i_PEC, i_SR, i_ER};
`endif

  // Last block ends on an odd row/column; an unpaired trailing one is skipped.
  assign w_col_last = w_col_lim[0] ? w_col_lim : w_col_lim - 11'd1;
  assign w_row_last = w_row_lim[0] ? w_row_lim : w_row_lim - 11'd1;
  assign w_last     = (r_row_cnt == w_row_last) && (r_col_cnt == w_col_last);

  assign w_pix       = w_line_act & i_de & ~w_vs_rise & w_in_win;
  assign w_lb_idx    = r_col_cnt[C_LB_AW:1];
  assign w_addr_full = {12'd0, r_row_cnt[10:1]} * {12'd0, i_hres[10:1]} +
                       {12'd0, r_col_cnt[10:1]};
  assign w_wdata     = {r_lb_rd, r_hold_px, i_data};

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state <= S_WIDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_vs_rise) begin
      w_state_nxt = S_WARM;
    end else begin
      case (r_state)
        S_WIDLE: w_state_nxt = S_WIDLE;
        S_WARM: begin
          if (r_row_cnt >= i_vres)
            w_state_nxt = S_WIDLE;
          else if (i_de)
            w_state_nxt = r_row_cnt[0] ? S_WODD : S_WEVEN;
        end
        S_WEVEN, S_WODD: if (w_de_fall) w_state_nxt = S_WARM;
        default: w_state_nxt = S_WIDLE;
      endcase
    end
  end

  always_comb begin
    w_line_act = 1'b0;
    case (r_state)
      S_WARM, S_WEVEN, S_WODD: w_line_act = 1'b1;
      default:                 w_line_act = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_de_d    <= 1'b0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else begin
      r_vsync_d <= i_vsync;
      r_de_d    <= i_de;
      if (w_vs_rise) begin
        r_col_cnt <= '0;
        r_row_cnt <= '0;
      end else if (w_de_fall) begin
        r_col_cnt <= '0;
        r_row_cnt <= r_row_cnt + 11'd1;
      end else if (i_de) begin
        r_col_cnt <= r_col_cnt + 11'd1;
      end
    end
  end

  // Pixel holding registers and line buffer carry no reset.
  always_ff @(posedge i_clk) begin
    if (w_pix && !r_col_cnt[0])
      r_hold_px <= i_data;
    if (w_pix && !r_row_cnt[0] && r_col_cnt[0])
      r_linebuf[w_lb_idx] <= {r_hold_px, i_data};
    if (w_pix && r_row_cnt[0] && !r_col_cnt[0])
      r_lb_rd <= r_linebuf[w_lb_idx];
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      wr.wen        <= 1'b1;
      wr.waddr      <= '0;
      wr.wdata      <= '0;
      wr.frame_done <= 1'b0;
    end else begin
      wr.wen        <= 1'b1;
      wr.frame_done <= 1'b0;
      if (w_pix && r_row_cnt[0] && r_col_cnt[0]) begin
        wr.wen        <= 1'b0;
        wr.waddr      <= w_addr_full[ADDR_WIDTH-1:0];
        wr.wdata      <= w_wdata;
        wr.frame_done <= w_last;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_write_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_write_control
// Description : Directed bench for memory_write_control (2x2 block packing).
// Revision    : 1.0  initial release
// ============================================================================
module tb_memory_write_control;
  localparam int DW = 24;
  localparam int MW = 96;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0, hsync = 1'b0, de = 1'b0;
  logic [DW-1:0] data = '0;
  logic [10:0]   hres = 11'd4, vres = 11'd2;
  logic [10:0]   psc = 11'd0, pec = 11'd2047, sr = 11'd0, er = 11'd2047;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] q_addr[$];
  logic [MW-1:0] q_data[$];
  logic          q_fd[$];
  int            n_fd_stray = 0;

  always #5 clk = ~clk;

  memory_write_control_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) wr_if ();

  memory_write_control #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .rst(rst), .i_vsync(vsync), .i_hsync(hsync), .i_de(de),
    .i_data(data), .i_hres(hres), .i_vres(vres), .i_PSC(psc), .i_PEC(pec),
    .i_SR(sr), .i_ER(er), .wr(wr_if)
  );

  always @(negedge clk) begin
    if (wr_if.wen === 1'b0) begin
      q_addr.push_back(wr_if.waddr);
      q_data.push_back(wr_if.wdata);
      q_fd.push_back(wr_if.frame_done);
    end else if (wr_if.frame_done === 1'b1) begin
      n_fd_stray++;
    end
  end

  function automatic logic [DW-1:0] pix(input logic [7:0] tg, input int r, input int c);
    return {tg, 8'(r), 8'(c)};
  endfunction

  function automatic logic [MW-1:0] blk(input logic [7:0] tg, input int br, input int bc);
    return {pix(tg, 2*br, 2*bc), pix(tg, 2*br, 2*bc+1),
            pix(tg, 2*br+1, 2*bc), pix(tg, 2*br+1, 2*bc+1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    q_addr.delete();
    q_data.delete();
    q_fd.delete();
    n_fd_stray = 0;
  endtask

  task automatic chk_wr(input string tag, input int idx, input int addr,
                        input logic [7:0] tg, input int br, input int bc, input logic fd);
    logic [AW-1:0] a;
    logic [MW-1:0] d;
    logic          f;
    a = 'x; d = 'x; f = 1'bx;
    if (idx < q_addr.size()) begin
      a = q_addr[idx]; d = q_data[idx]; f = q_fd[idx];
    end
    chk({tag, "_addr"}, 128'(a), 128'(addr));
    chk({tag, "_data"}, 128'(d), 128'(blk(tg, br, bc)));
    chk({tag, "_fd"},   128'(f), 128'(fd));
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; step(); step();
    vsync = 1'b0; step(); step();
  endtask

  task automatic line(input int r, input int delen, input logic [7:0] tg);
    for (int c = 0; c < delen; c++) begin
      de = 1'b1; data = pix(tg, r, c); step();
    end
    de = 1'b0; data = '0;
    repeat (4) step();
  endtask

  task automatic frame(input int h, input int v, input int delen, input logic [7:0] tg);
    hres = 11'(h); vres = 11'(v);
    vs_pulse();
    for (int r = 0; r < v; r++) line(r, delen, tg);
    repeat (4) step();
  endtask

  task automatic chk_win(input string tag, input logic [7:0] tg);
`ifdef WMEM_WIN_EN
    chk({tag, "_nwr"}, 128'(q_addr.size()), 128'(2));
    chk_wr({tag, "_w0"}, 0, 5, tg, 1, 1, 1'b0);
    chk_wr({tag, "_w1"}, 1, 6, tg, 1, 2, 1'b1);
`else
    chk({tag, "_nwr"}, 128'(q_addr.size()), 128'(8));
    for (int i = 0; i < 8; i++)
      chk_wr($sformatf("%s_w%0d", tag, i), i, i, tg, i / 4, i % 4, i == 7);
`endif
    chk({tag, "_stray"}, 128'(n_fd_stray), 128'(0));
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    chk("rst_wen",   128'(wr_if.wen),        128'(1));
    chk("rst_waddr", 128'(wr_if.waddr),      128'(0));
    chk("rst_wdata", 128'(wr_if.wdata),      128'(0));
    chk("rst_fd",    128'(wr_if.frame_done), 128'(0));
    rst = 1'b0;
    step();

    // 4x2 full frame
    clr();
    frame(4, 2, 4, 8'hA1);
    chk("f4x2_nwr", 128'(q_addr.size()), 128'(2));
    chk_wr("f4x2_w0", 0, 0, 8'hA1, 0, 0, 1'b0);
    chk_wr("f4x2_w1", 1, 1, 8'hA1, 0, 1, 1'b1);

    // Aligned window on 8x4
    clr();
    psc = 11'd2; pec = 11'd5; sr = 11'd2; er = 11'd3;
    frame(8, 4, 8, 8'hB2);
    chk_win("win", 8'hB2);

    // Unaligned window snaps to the same blocks
    clr();
    psc = 11'd3; pec = 11'd4; sr = 11'd3; er = 11'd2;
    frame(8, 4, 8, 8'hC3);
    chk_win("uwin", 8'hC3);
    psc = 11'd0; pec = 11'd2047; sr = 11'd0; er = 11'd2047;

    // vsync rises mid odd line: partial block dropped
    clr();
    hres = 11'd4; vres = 11'd2;
    vs_pulse();
    line(0, 4, 8'hD4);
    de = 1'b1; data = pix(8'hD4, 1, 0); step();
    vsync = 1'b1; data = pix(8'hD4, 1, 1); step();
    de = 1'b0; step();
    vsync = 1'b0;
    repeat (4) step();
    chk("abort_nwr", 128'(q_addr.size()), 128'(0));
    frame(4, 2, 4, 8'hE5);
    chk("abort_next_nwr", 128'(q_addr.size()), 128'(2));
    chk_wr("abort_next_w0", 0, 0, 8'hE5, 0, 0, 1'b0);
    chk_wr("abort_next_w1", 1, 1, 8'hE5, 0, 1, 1'b1);

    // Reset mid odd line
    clr();
    vs_pulse();
    line(0, 4, 8'h66);
    de = 1'b1; data = pix(8'h66, 1, 0); step();
    rst = 1'b1; data = pix(8'h66, 1, 1); step();
    chk("mrst_wen",   128'(wr_if.wen),   128'(1));
    chk("mrst_waddr", 128'(wr_if.waddr), 128'(0));
    chk("mrst_wdata", 128'(wr_if.wdata), 128'(0));
    rst = 1'b0;
    data = pix(8'h66, 1, 2); step();
    data = pix(8'h66, 1, 3); step();
    de = 1'b0; repeat (4) step();
    line(2, 4, 8'h66);
    line(3, 4, 8'h66);
    chk("mrst_nwr", 128'(q_addr.size()), 128'(0));

    // Odd hres with overlong de
    clr();
    frame(5, 2, 7, 8'h77);
    chk("h5_nwr", 128'(q_addr.size()), 128'(2));
    chk_wr("h5_w0", 0, 0, 8'h77, 0, 0, 1'b0);
    chk_wr("h5_w1", 1, 1, 8'h77, 0, 1, 1'b1);
    chk("h5_stray", 128'(n_fd_stray), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
